// File: rtl/rf_wb_sched_pkg.sv
// Shared widths and the buffered writeback entry type for the register-file
// write-port scheduler.
package rf_wb_sched_pkg;

    localparam int XLEN      = 32;
    localparam int RFIDX_W   = 5;
    localparam int RFREG_NUM = 32;

    typedef struct packed {
        logic [RFIDX_W-1:0] wa;
        logic [XLEN-1:0]    wd;
    } wb_entry_t;

endpackage

// File: rtl/rf_wb_sched_wb_fifo.sv
// Small synchronous FIFO of writeback entries with a combinational head
// and full/empty flags derived from a registered occupancy count.
module wb_fifo
    import rf_wb_sched_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      push,
    input  wb_entry_t push_data,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W:0]     count_reg;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/rf_wb_sched.sv
// Arbitrates the single register-file write port between pipeline writeback
// (A, priority) and buffered long-latency results (B), with a RAW/WAW scoreboard.
module rf_wb_sched
    import rf_wb_sched_pkg::*;
#(
    parameter int BDEPTH       = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 a_we,
    input  logic [RFIDX_W-1:0]   a_wa,
    input  logic [XLEN-1:0]      a_wd,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [RFIDX_W-1:0]   b_wa,
    input  logic [XLEN-1:0]      b_wd,
    input  logic                 iss_valid,
    input  logic [RFIDX_W-1:0]   iss_rd,
    input  logic [RFIDX_W-1:0]   q_ra1,
    input  logic [RFIDX_W-1:0]   q_ra2,
    input  logic [RFIDX_W-1:0]   q_rd,
    output logic                 stall,
    output logic                 rf_we,
    output logic [RFIDX_W-1:0]   rf_wa,
    output logic [XLEN-1:0]      rf_wd,
    output logic [RFREG_NUM-1:0] pending
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic                 run_reg;
    logic                 hold_reg;
    logic [CNT_W-1:0]     starve_cnt_reg;
    logic [CNT_W-1:0]     starve_cnt_next;
    logic [RFREG_NUM-1:0] pending_reg;
    logic [RFREG_NUM-1:0] pending_set;
    logic [RFREG_NUM-1:0] pending_clr;
    wb_entry_t            head;
    wb_entry_t            push_data;
    logic                 full;
    logic                 empty;
    logic                 a_active;
    logic                 push;
    logic                 pop;

    // run_reg masks everything until the first edge after reset release.
    assign a_active  = run_reg && a_we && (a_wa != '0);
    assign b_ready   = run_reg && !full;
    assign push      = b_valid && b_ready && (b_wa != '0);
    assign pop       = run_reg && !a_active && !empty;
    assign push_data = '{wa: b_wa, wd: b_wd};

    wb_fifo #(
        .DEPTH (BDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        rf_we = 1'b0;
        rf_wa = '0;
        rf_wd = '0;
        if (a_active) begin
            rf_we = 1'b1;
            rf_wa = a_wa;
            rf_wd = a_wd;
        end else if (pop) begin
            rf_we = 1'b1;
            rf_wa = head.wa;
            rf_wd = head.wd;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < RFREG_NUM; gi++) begin : g_sb
            assign pending_set[gi] = (gi != 0) && iss_valid && (iss_rd == RFIDX_W'(gi));
            assign pending_clr[gi] = pop && (head.wa == RFIDX_W'(gi));
        end
    endgenerate

    always_comb begin
        starve_cnt_next = '0;
        if (full && a_active) begin
            starve_cnt_next = (starve_cnt_reg == CNT_W'(STARVE_LIMIT)) ?
                              starve_cnt_reg : starve_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_reg        <= 1'b0;
            hold_reg       <= 1'b0;
            starve_cnt_reg <= '0;
            pending_reg    <= '0;
        end else begin
            run_reg        <= 1'b1;
            starve_cnt_reg <= starve_cnt_next;
            // A pop releases the hold; otherwise it latches once the limit is reached.
            if (pop)
                hold_reg <= 1'b0;
            else if (starve_cnt_next == CNT_W'(STARVE_LIMIT))
                hold_reg <= 1'b1;
            // Issue of a new op to r wins over retirement of an older one to r.
            pending_reg <= (pending_reg & ~pending_clr) | pending_set;
        end
    end

    assign pending = pending_reg;
    assign stall   = pending_reg[q_ra1] | pending_reg[q_ra2] | pending_reg[q_rd] | hold_reg;

    a_write_not_pending: assert property (@(posedge clk) disable iff (!rstn)
        !(a_active && pending_reg[a_wa]));

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed bench: stimulus pushes expected register-file writes into a queue,
// a negedge monitor pops and compares every rf_we cycle.
module tb_rf_wb_sched;
    import rf_wb_sched_pkg::*;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 a_we = 1'b0;
    logic [RFIDX_W-1:0]   a_wa = '0;
    logic [XLEN-1:0]      a_wd = '0;
    logic                 b_valid = 1'b0;
    logic                 b_ready;
    logic [RFIDX_W-1:0]   b_wa = '0;
    logic [XLEN-1:0]      b_wd = '0;
    logic                 iss_valid = 1'b0;
    logic [RFIDX_W-1:0]   iss_rd = '0;
    logic [RFIDX_W-1:0]   q_ra1 = '0;
    logic [RFIDX_W-1:0]   q_ra2 = '0;
    logic [RFIDX_W-1:0]   q_rd = '0;
    logic                 stall;
    logic                 rf_we;
    logic [RFIDX_W-1:0]   rf_wa;
    logic [XLEN-1:0]      rf_wd;
    logic [RFREG_NUM-1:0] pending;

    int checks = 0;
    int errors = 0;
    logic [RFIDX_W+XLEN-1:0] exp_q[$];
    logic [RFIDX_W+XLEN-1:0] exp_e;

    rf_wb_sched #(.BDEPTH(2), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rstn(rstn),
        .a_we(a_we), .a_wa(a_wa), .a_wd(a_wd),
        .b_valid(b_valid), .b_ready(b_ready), .b_wa(b_wa), .b_wd(b_wd),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .q_ra1(q_ra1), .q_ra2(q_ra2), .q_rd(q_rd),
        .stall(stall), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input logic we, input logic [RFIDX_W-1:0] wa, input logic [XLEN-1:0] wd);
        a_we = we; a_wa = wa; a_wd = wd;
        if (we && wa != '0) exp_q.push_back({wa, wd});
    endtask

    task automatic drv_b(input logic v, input logic [RFIDX_W-1:0] wa, input logic [XLEN-1:0] wd);
        b_valid = v; b_wa = wa; b_wd = wd;
    endtask

    // Scoreboard monitor: every register-file write must match the queue head.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual=x%0d:%0h required=no_write", rf_wa, rf_wd);
            end else begin
                exp_e = exp_q.pop_front();
                if ({rf_wa, rf_wd} !== exp_e) begin
                    errors++;
                    $display("FAIL rf_write actual=x%0d:%0h required=x%0d:%0h",
                             rf_wa, rf_wd, exp_e[XLEN+RFIDX_W-1:XLEN], exp_e[XLEN-1:0]);
                end else begin
                    $display("write x%0d = %08h", rf_wa, rf_wd);
                end
            end
        end
    end

    initial begin
        // Reset then idle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_b_ready", b_ready, 0);
            chk("rst_stall", stall, 0);
            chk("rst_rf_we", rf_we, 0);
            chk("rst_pending", pending, 0);
        end
        next(); rstn = 1'b1;
        @(negedge clk); chk("rel_rf_we", rf_we, 0);
        next();
        @(negedge clk); chk("rel_b_ready", b_ready, 1); chk("rel_rf_we2", rf_we, 0);

        // A priority over B in the same cycle
        next(); drv_a(1, 5, 32'h11); drv_b(1, 7, 32'h22); exp_q.push_back({5'd7, 32'h22});
        @(negedge clk); chk("prio_b_ready", b_ready, 1); chk("prio_a_wa", rf_wa, 5);
        next(); drv_a(0, 0, 0); drv_b(0, 0, 0);
        @(negedge clk); chk("prio_b_wa", rf_wa, 7);
        next();
        @(negedge clk); chk("prio_idle", rf_we, 0);

        // Scoreboard stall on x9
        next(); iss_valid = 1; iss_rd = 9;
        @(negedge clk); chk("sb_stall_pre", stall, 0); chk("sb_pend_pre", pending, 0);
        next(); iss_valid = 0; iss_rd = 0; q_ra1 = 9;
        @(negedge clk); chk("sb_stall1", stall, 1); chk("sb_pend1", pending, 32'h200);
        next();
        @(negedge clk); chk("sb_stall2", stall, 1);
        next(); drv_b(1, 9, 32'h99); exp_q.push_back({5'd9, 32'h99});
        @(negedge clk); chk("sb_stall3", stall, 1);
        next(); drv_b(0, 0, 0);
        @(negedge clk); chk("sb_stall_wr", stall, 1); chk("sb_wr_wa", rf_wa, 9);
        next();
        @(negedge clk); chk("sb_stall_clr", stall, 0); chk("sb_pend_clr", pending, 0);

        // Full buffer and pointer wrap while A is busy
        next(); q_ra1 = 0; drv_a(1, 20, 32'hA0); drv_b(1, 1, 32'h101);
        @(negedge clk); chk("full_rdy0", b_ready, 1);
        next(); drv_a(1, 21, 32'hA1); drv_b(1, 2, 32'h102);
        @(negedge clk); chk("full_rdy1", b_ready, 1);
        next(); drv_a(1, 22, 32'hA2); drv_b(1, 3, 32'h103);
        exp_q.push_back({5'd1, 32'h101}); exp_q.push_back({5'd2, 32'h102}); exp_q.push_back({5'd3, 32'h103});
        @(negedge clk); chk("full_rdy2", b_ready, 0);
        next(); drv_a(0, 0, 0);
        @(negedge clk); chk("full_rdy3", b_ready, 0); chk("full_drain1", rf_wa, 1);
        next();
        @(negedge clk); chk("full_rdy4", b_ready, 1); chk("full_drain2", rf_wa, 2);
        next(); drv_b(0, 0, 0);
        @(negedge clk); chk("full_drain3", rf_wa, 3);
        next();
        @(negedge clk); chk("full_idle", rf_we, 0);

        // Starvation: buffer full while A writes continuously
        for (int i = 0; i < 10; i++) begin
            next(); drv_a(1, RFIDX_W'(20 + (i % 4)), 32'h500 + i);
            drv_b(i < 2, RFIDX_W'(12 + i), 32'h600 + i);
            @(negedge clk);
            if (i >= 2) chk("starve_rdy", b_ready, 0);
            chk("starve_no_stall", stall, 0);
        end
        next(); drv_a(0, 0, 0); drv_b(0, 0, 0);
        exp_q.push_back({5'd12, 32'h600}); exp_q.push_back({5'd13, 32'h601});
        @(negedge clk); chk("starve_hold", stall, 1); chk("starve_pop_wa", rf_wa, 12);
        next();
        @(negedge clk); chk("starve_release", stall, 0);
        next();
        @(negedge clk); chk("starve_idle", rf_we, 0);

        // x0 result is dropped
        next(); drv_b(1, 0, 32'hDEAD);
        @(negedge clk); chk("x0_rdy", b_ready, 1);
        next(); drv_b(0, 0, 0);
        @(negedge clk); chk("x0_no_write", rf_we, 0); chk("x0_pending", pending, 0);

        // Reset mid-operation with two entries buffered and x6 pending
        next(); drv_a(1, 25, 32'h250); drv_b(1, 3, 32'h303); iss_valid = 1; iss_rd = 6;
        next(); drv_a(1, 26, 32'h260); drv_b(1, 4, 32'h404); iss_valid = 0; iss_rd = 0; q_rd = 6;
        @(negedge clk); chk("mid_pending", pending, 32'h40); chk("mid_stall", stall, 1);
        next(); drv_a(1, 27, 32'h270); drv_b(0, 0, 0);
        @(negedge clk); chk("mid_full", b_ready, 0);
        next(); a_we = 1; a_wa = 28; a_wd = 32'h280; rstn = 1'b0;
        @(negedge clk);
        chk("mid_rst_we", rf_we, 0); chk("mid_rst_pend", pending, 0);
        chk("mid_rst_rdy", b_ready, 0); chk("mid_rst_stall", stall, 0);
        next(); drv_a(0, 0, 0); q_rd = 0; rstn = 1'b1;
        @(negedge clk); chk("post_rst_we0", rf_we, 0);
        for (int i = 0; i < 3; i++) begin
            next();
            @(negedge clk); chk("post_rst_rdy", b_ready, 1); chk("post_rst_no_drain", rf_we, 0);
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
